// File: rtl/activity_pkg.sv
`default_nettype none
// ============================================================================
// Module : activity_pkg
// Brief  : Shared definitions for the activity scheduler: pulse-generator mode
//          codes, the hybrid walk/jog/run schedule, FSM state encoding, the
//          elapsed-seconds width and a saturating increment helper.
// Rev    : 1.0  initial release
// ============================================================================
package activity_pkg;

  // Mode codes shared with the pulse generator (HYBRID never leaves this block)
  localparam logic [1:0] MODE_WALK   = 2'b00;
  localparam logic [1:0] MODE_JOG    = 2'b01;
  localparam logic [1:0] MODE_RUN    = 2'b10;
  localparam logic [1:0] MODE_HYBRID = 2'b11;

  // Hybrid schedule, element [i] is the generator mode for segment i:
  // walk, jog, run, jog, walk
  localparam int         NUM_SEGS  = 5;
  localparam logic [2:0] SEG_LAST  = 3'd4;
  localparam logic [4:0][1:0] HYB_SCHED = {MODE_WALK, MODE_JOG, MODE_RUN,
                                           MODE_JOG, MODE_WALK};

  localparam int SECONDS_W = 12;
  localparam int CNT_W     = 8;   // holds SEG_SECS-1 for SEG_SECS up to 255
  localparam int GAP_W     = 4;   // holds GAP_CYCLES-1 for GAP_CYCLES up to 15

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_SWITCH = 2'd3
  } state_e;

  function automatic logic [SECONDS_W-1:0] sat_inc(input logic [SECONDS_W-1:0] v);
    return (v == {SECONDS_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/activity_scheduler_tick_detect.sv
`default_nettype none
// ============================================================================
// Module : tick_detect
// Brief  : Rising-edge detector for the 1 Hz square wave. The history flop
//          resets to 1 so a wave that is already high at reset release does
//          not produce a spurious tick.
// Ports  : clk    in  system clock
//          reset  in  synchronous active-high reset
//          clk1hz in  1 Hz square wave, synchronous to clk
//          tick   out one-cycle pulse while clk1hz is high and was low
// Rev    : 1.0  initial release
// ============================================================================
module tick_detect (
  input  logic clk,
  input  logic reset,
  input  logic clk1hz,
  output logic tick
);

  logic clk1hz_q;
  logic clk1hz_d;

  always_comb begin
    clk1hz_d = clk1hz;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk1hz_q <= 1'b1;
    end else begin
      clk1hz_q <= clk1hz_d;
    end
  end

  assign tick = clk1hz & ~clk1hz_q;

endmodule
`default_nettype wire

// File: rtl/activity_scheduler.sv
`default_nettype none
// ============================================================================
// Module : activity_scheduler
// Brief  : Drives the step-pulse generator's start/mode. Latches the user's
//          request, walks the hybrid walk/jog/run schedule on 1 Hz ticks with
//          a start-low guard gap on each rate change, and counts elapsed
//          active seconds (saturating).
// Config : HYBRID_REPEAT_EN - when defined the hybrid schedule loops from
//          segment 4 back to segment 0; otherwise it holds at segment 4.
// Ports  : clk       in   system clock
//          reset     in   synchronous active-high reset
//          clk1hz    in   1 Hz square wave (rising edge = one second)
//          start     in   user run enable, level-sensitive
//          mode      in   [1:0] 00 walk, 01 jog, 10 run, 11 hybrid
//          gen_start out  pulse generator start
//          gen_mode  out  [1:0] pulse generator mode, never 11
//          seg       out  [2:0] current hybrid segment, 0 otherwise
//          seconds   out  [11:0] elapsed active seconds, saturating
//          busy      out  high in RUN or SWITCH
// Rev    : 1.0  initial release
// ============================================================================
module activity_scheduler
  import activity_pkg::*;
#(
  parameter int SEG_SECS   = 20,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk1hz,
  input  logic                 start,
  input  logic [1:0]           mode,
  output logic                 gen_start,
  output logic [1:0]           gen_mode,
  output logic [2:0]           seg,
  output logic [SECONDS_W-1:0] seconds,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEG_SECS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic tick;

  tick_detect u_tick_detect (
    .clk    (clk),
    .reset  (reset),
    .clk1hz (clk1hz),
    .tick   (tick)
  );

  state_e               state_q,     state_d;
  logic [1:0]           mode_q,      mode_d;
  logic [1:0]           gen_mode_q,  gen_mode_d;
  logic                 gen_start_q, gen_start_d;
  logic [2:0]           seg_q,       seg_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [SECONDS_W-1:0] seconds_q,   seconds_d;
  logic [GAP_W-1:0]     gap_q,       gap_d;
  logic                 pend_q,      pend_d;   // expiry deferred out of SWITCH
  logic                 busy_q,      busy_d;

  logic       is_hybrid;
  logic       expire;
  logic [2:0] seg_next;
  logic [1:0] next_mode;

  assign is_hybrid = (mode_q == MODE_HYBRID);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    gen_mode_d = gen_mode_q;
    seg_d      = seg_q;
    cnt_d      = cnt_q;
    seconds_d  = seconds_q;
    gap_d      = gap_q;
    pend_d     = pend_q;
    expire     = 1'b0;

`ifdef HYBRID_REPEAT_EN
    seg_next = (seg_q == SEG_LAST) ? 3'd0 : seg_q + 3'd1;
`else
    seg_next = (seg_q == SEG_LAST) ? SEG_LAST : seg_q + 3'd1;
`endif
    next_mode = HYB_SCHED[seg_next];

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          mode_d  = mode;
        end
      end

      ST_LOAD: begin
        // Mode is presented one cycle ahead of the generator's start edge
        state_d    = ST_RUN;
        gen_mode_d = is_hybrid ? MODE_WALK : mode_q;
        seg_d      = 3'd0;
        cnt_d      = '0;
        seconds_d  = '0;
        pend_d     = 1'b0;
      end

      ST_RUN: begin
        if (tick) begin
          seconds_d = sat_inc(seconds_q);
          if (is_hybrid && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        expire = is_hybrid && (pend_q || (tick && (cnt_q == CNT_LAST)));
        if (expire) begin
          cnt_d  = '0;
          pend_d = 1'b0;
          seg_d  = seg_next;
          if (next_mode != gen_mode_q) begin
            gen_mode_d = next_mode;
            gap_d      = GAP_LAST;
            state_d    = ST_SWITCH;
          end
        end
      end

      ST_SWITCH: begin
        // Seconds keep counting; a segment expiry is parked until RUN resumes
        if (tick) begin
          seconds_d = sat_inc(seconds_q);
          if (cnt_q == CNT_LAST) begin
            pend_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (gap_q == '0) begin
          state_d = ST_RUN;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Dropping start wins over any tick or segment event in the same cycle
    if ((state_q != ST_IDLE) && !start) begin
      state_d    = ST_IDLE;
      gen_mode_d = MODE_WALK;
      seg_d      = 3'd0;
      seconds_d  = seconds_q;
      cnt_d      = cnt_q;
      pend_d     = 1'b0;
    end

    // The cycle leaving LOAD only publishes the mode; start follows a cycle later
    gen_start_d = (state_d == ST_RUN) && (state_q != ST_LOAD);
    busy_d      = (state_d == ST_RUN) || (state_d == ST_SWITCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_WALK;
      gen_mode_q  <= MODE_WALK;
      gen_start_q <= 1'b0;
      seg_q       <= 3'd0;
      cnt_q       <= '0;
      seconds_q   <= '0;
      gap_q       <= '0;
      pend_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      gen_mode_q  <= gen_mode_d;
      gen_start_q <= gen_start_d;
      seg_q       <= seg_d;
      cnt_q       <= cnt_d;
      seconds_q   <= seconds_d;
      gap_q       <= gap_d;
      pend_q      <= pend_d;
      busy_q      <= busy_d;
    end
  end

  assign gen_start = gen_start_q;
  assign gen_mode  = gen_mode_q;
  assign seg       = seg_q;
  assign seconds   = seconds_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_activity_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_activity_scheduler
// Brief  : Self-checking bench for activity_scheduler (SEG_SECS=2,
//          GAP_CYCLES=2): vector table, hybrid/stop/saturation sequences and
//          a randomized run against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_activity_scheduler;

  localparam int SEG = 2;
  localparam int GAP = 2;
`ifdef HYBRID_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk1hz = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        gen_start;
  logic [1:0]  gen_mode;
  logic [2:0]  seg;
  logic [11:0] seconds;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  activity_scheduler #(.SEG_SECS(SEG), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk1hz    (clk1hz),
    .start     (start),
    .mode      (mode),
    .gen_start (gen_start),
    .gen_mode  (gen_mode),
    .seg       (seg),
    .seconds   (seconds),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural reference model ----------------
  int sched[5] = '{0, 1, 2, 1, 0};
  bit m_prev = 1'b1;
  bit m_idle = 1'b1;
  bit m_load = 1'b0;
  int m_gap = 0;      // remaining guard-gap cycles; >0 while generator is paused
  int m_umode = 0, m_gm = 0, m_gs = 0, m_seg = 0, m_cnt = 0, m_sec = 0;
  int m_pend = 0, m_busy = 0;

  function automatic void model_step(logic rst, logic c1, logic st, logic [1:0] md);
    bit tk;
    bit hyb;
    bit exp_now;
    int nseg;
    tk = c1 && !m_prev;
    if (rst) begin
      m_prev = 1'b1; m_idle = 1'b1; m_load = 1'b0; m_gap = 0; m_umode = 0;
      m_gm = 0; m_gs = 0; m_seg = 0; m_cnt = 0; m_sec = 0; m_pend = 0; m_busy = 0;
      return;
    end
    m_prev = c1;
    hyb = (m_umode == 3);
    if (m_idle) begin
      if (st) begin
        m_idle = 1'b0; m_load = 1'b1; m_umode = int'(md);
      end
    end else if (!st) begin
      m_idle = 1'b1; m_load = 1'b0; m_gap = 0; m_pend = 0;
      m_gm = 0; m_seg = 0; m_gs = 0; m_busy = 0;
    end else if (m_load) begin
      m_load = 1'b0; m_gm = hyb ? 0 : m_umode; m_seg = 0; m_cnt = 0;
      m_sec = 0; m_pend = 0; m_gs = 0; m_busy = 1;
    end else begin
      m_busy = 1;
      if (tk && m_sec < 4095) m_sec++;
      if (m_gap > 0) begin
        if (tk) begin
          if (m_cnt == SEG - 1) m_pend = 1;
          else m_cnt++;
        end
        m_gap--;
        m_gs = (m_gap == 0) ? 1 : 0;
      end else begin
        exp_now = hyb && (m_pend != 0 || (tk && m_cnt == SEG - 1));
        if (tk && hyb) m_cnt++;
        m_gs = 1;
        if (exp_now) begin
          m_cnt = 0; m_pend = 0;
          nseg = (m_seg < 4) ? m_seg + 1 : (REPEAT ? 0 : 4);
          m_seg = nseg;
          if (sched[nseg] != m_gm) begin
            m_gm = sched[nseg]; m_gap = GAP; m_gs = 0;
          end
        end
      end
    end
  endfunction

  // ---------------- hybrid monitor ----------------
  bit mon_en = 1'b0;
  int last_gm = -1;
  bit seen_hi = 1'b0;
  int low_run = 0;
  int gm_seen[$];
  int runs[$];

  task automatic cycle();
    model_step(reset, clk1hz, start, mode);
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (busy && int'(gen_mode) != last_gm) begin
        gm_seen.push_back(int'(gen_mode));
        last_gm = int'(gen_mode);
      end
      if (gen_start) begin
        if (low_run > 0) runs.push_back(low_run);
        low_run = 0;
        seen_hi = 1'b1;
      end else if (busy && seen_hi) begin
        low_run++;
      end
    end
  endtask

  task automatic check_all(string name, logic gs, logic [1:0] gm, logic [2:0] sg,
                           logic bz, logic [11:0] sc);
    n_tests++;
    if (gen_start !== gs || gen_mode !== gm || seg !== sg || busy !== bz || seconds !== sc) begin
      n_fail++;
      $display("FAIL %s: got gs=%b gm=%b seg=%0d busy=%b sec=%0d, want gs=%b gm=%b seg=%0d busy=%b sec=%0d",
               name, gen_start, gen_mode, seg, busy, seconds, gs, gm, sg, bz, sc);
    end
  endtask

  task automatic check1(string name, int got, int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic do_tick();
    clk1hz = 1'b0;
    repeat (3) cycle();
    clk1hz = 1'b1;
    repeat (3) cycle();
  endtask

  task automatic fast_tick();
    clk1hz = 1'b0;
    cycle();
    clk1hz = 1'b1;
    cycle();
  endtask

  task automatic start_run(logic [1:0] md);
    reset = 1'b1; start = 1'b0; clk1hz = 1'b1;
    cycle();
    reset = 1'b0; start = 1'b1; mode = md;
    repeat (3) cycle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, c1, st;
    logic [1:0]  md;
    logic        gs;
    logic [1:0]  gm;
    logic [2:0]  sg;
    logic        bz;
    logic [11:0] sc;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(int rst, int c1, int st, int md, int gs, int gm,
                              int sg, int bz, int sc);
    vec_t v;
    v.rst = 1'(rst); v.c1 = 1'(c1); v.st = 1'(st); v.md = 2'(md);
    v.gs = 1'(gs); v.gm = 2'(gm); v.sg = 3'(sg); v.bz = 1'(bz); v.sc = 12'(sc);
    return v;
  endfunction

  initial begin
    int exp_gm[5] = '{0, 1, 2, 1, 0};
    bit found;

    //            rst c1 st md  gs gm sg bz sec
    tbl[0]  = mk(1, 1, 0, 0,  0, 0, 0, 0, 0);   // reset state
    tbl[1]  = mk(0, 1, 1, 1,  0, 0, 0, 0, 0);   // start sampled -> LOAD
    tbl[2]  = mk(0, 1, 1, 1,  0, 1, 0, 1, 0);   // mode valid, start not yet
    tbl[3]  = mk(0, 1, 1, 1,  1, 1, 0, 1, 0);   // generator started
    tbl[4]  = mk(0, 0, 1, 2,  1, 1, 0, 1, 0);   // mode change ignored
    tbl[5]  = mk(0, 1, 1, 2,  1, 1, 0, 1, 1);   // tick
    tbl[6]  = mk(0, 1, 1, 2,  1, 1, 0, 1, 1);
    tbl[7]  = mk(0, 0, 1, 2,  1, 1, 0, 1, 1);
    tbl[8]  = mk(0, 1, 1, 2,  1, 1, 0, 1, 2);   // tick
    tbl[9]  = mk(0, 1, 0, 2,  0, 0, 0, 0, 2);   // stop, seconds held
    tbl[10] = mk(0, 0, 0, 0,  0, 0, 0, 0, 2);
    tbl[11] = mk(0, 1, 0, 0,  0, 0, 0, 0, 2);   // tick while idle not counted
    tbl[12] = mk(0, 1, 1, 0,  0, 0, 0, 0, 2);   // LOAD, seconds not yet cleared
    tbl[13] = mk(0, 1, 1, 0,  0, 0, 0, 1, 0);
    tbl[14] = mk(0, 1, 1, 0,  1, 0, 0, 1, 0);
    tbl[15] = mk(0, 0, 1, 0,  1, 0, 0, 1, 0);
    tbl[16] = mk(1, 1, 1, 0,  0, 0, 0, 0, 0);   // reset with a tick mid-RUN
    tbl[17] = mk(0, 1, 0, 0,  0, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      reset = tbl[i].rst; clk1hz = tbl[i].c1; start = tbl[i].st; mode = tbl[i].md;
      cycle();
      check_all($sformatf("vec%0d", i), tbl[i].gs, tbl[i].gm, tbl[i].sg, tbl[i].bz, tbl[i].sc);
    end

    // ---- hybrid schedule, 10 ticks ----
    start_run(2'b11);
    mon_en = 1'b1;
    repeat (10) do_tick();
    repeat (4) cycle();
    mon_en = 1'b0;
    check1("hyb_mode_count", gm_seen.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check1($sformatf("hyb_mode%0d", i), (i < gm_seen.size()) ? gm_seen[i] : -1, exp_gm[i]);
    end
    check1("hyb_gap_count", runs.size(), 4);
    foreach (runs[i]) check1($sformatf("hyb_gap%0d_len", i), runs[i], GAP);
    check1("hyb_final_seg", int'(seg), REPEAT ? 0 : 4);
    check1("hyb_seconds", int'(seconds), 10);
    check1("hyb_gen_start", int'(gen_start), 1);

    // ---- start dropped during the guard gap ----
    start_run(2'b11);
    do_tick();
    clk1hz = 1'b0;
    repeat (3) cycle();
    clk1hz = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (!gen_start) found = 1'b1;
    end
    check1("switch_seen", int'(found), 1);
    start = 1'b0;
    cycle();
    check_all("drop_in_switch", 1'b0, 2'b00, 3'd0, 1'b0, 12'd2);

    // ---- mode change while busy, then seconds saturation ----
    start_run(2'b00);
    mode = 2'b10;
    fast_tick();
    check1("mode_ignored", int'(gen_mode), 0);
    for (int i = 1; i < 4094; i++) fast_tick();
    check1("sec_4094", int'(seconds), 4094);
    fast_tick();
    check1("sec_4095", int'(seconds), 4095);
    repeat (5) fast_tick();
    check1("sec_saturated", int'(seconds), 4095);
    check1("sat_gen_mode", int'(gen_mode), 0);

    // ---- randomized run against the model ----
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 2) == 0) clk1hz = ~clk1hz;
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      cycle();
      check_all($sformatf("rand%0d", i), 1'(m_gs), 2'(m_gm), 3'(m_seg), 1'(m_busy), 12'(m_sec));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
